// File: rtl/attn_v_mul.sv
// Attention second stage: out = W * V in signed fixed point using one sequential MAC.
// Optional build macro ATTN_V_SATURATE_EN clamps each result instead of wrapping it.
module attn_v_mul #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEQ_LEN    = 64,
  parameter int unsigned EMBED_DIM  = 64,
  parameter int unsigned FRAC_BITS  = 14
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0]       W_flat,
  input  logic [DATA_WIDTH*SEQ_LEN*EMBED_DIM-1:0]     V_flat,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [DATA_WIDTH-1:0]                       out_data,
  output logic [$clog2(SEQ_LEN*EMBED_DIM)-1:0]        out_index,
  output logic [DATA_WIDTH*SEQ_LEN*EMBED_DIM-1:0]     out_flat
);

  localparam int unsigned NUM_OUT = SEQ_LEN * EMBED_DIM;
  localparam int unsigned IDX_W   = $clog2(NUM_OUT);
  localparam int unsigned I_W     = $clog2(SEQ_LEN);
  localparam int unsigned D_W     = $clog2(EMBED_DIM);
  localparam int unsigned PROD_W  = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W   = DATA_WIDTH + $clog2(SEQ_LEN);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, EMIT} state_e;

  state_e                    state_q, state_d;
  logic [I_W-1:0]            i_q, i_d, j_q, j_d;
  logic [D_W-1:0]            d_q, d_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic                      busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d, res_c;
  logic [IDX_W-1:0]          index_q, index_d, idx_c;
  logic                      wr_en_c;
  logic [DATA_WIDTH-1:0]     res_q [NUM_OUT];

  logic signed [DATA_WIDTH-1:0] w_el [SEQ_LEN][SEQ_LEN];
  logic signed [DATA_WIDTH-1:0] v_el [SEQ_LEN][EMBED_DIM];

  // Matrix views of the flat input buses.
  for (genvar m = 0; m < SEQ_LEN; m++) begin : g_w_row
    for (genvar n = 0; n < SEQ_LEN; n++) begin : g_w_col
      assign w_el[m][n] = W_flat[(m*SEQ_LEN+n)*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar n = 0; n < EMBED_DIM; n++) begin : g_v_col
      assign v_el[m][n] = V_flat[(m*EMBED_DIM+n)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_flat[k*DATA_WIDTH +: DATA_WIDTH] = res_q[k];
  end

  assign idx_c = IDX_W'(i_q) * IDX_W'(EMBED_DIM) + IDX_W'(d_q);

`ifdef ATTN_V_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    res_c = acc_q[DATA_WIDTH-1:0];
    if (acc_q > SAT_MAX)      res_c = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc_q < SAT_MIN) res_c = SAT_MIN[DATA_WIDTH-1:0];
  end
`else
  assign res_c = acc_q[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      d_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      d_q     <= d_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
    end
  end

  // Result memory backing out_flat; holds until overwritten by a later run.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_OUT); k++) res_q[k] <= '0;
    end else if (wr_en_c) begin
      res_q[idx_c] <= res_c;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    d_d     = d_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    wr_en_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          d_d     = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        prod_d  = PROD_W'(w_el[i_q][j_q]) * PROD_W'(v_el[j_q][d_q]);
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod_q >>> FRAC_BITS);
        if (j_q == I_W'(SEQ_LEN - 1)) begin
          state_d = WRITE;
        end else begin
          j_d     = j_q + I_W'(1);
          state_d = LOAD;
        end
      end
      WRITE: begin
        wr_en_c = 1'b1;
        data_d  = res_c;
        index_d = idx_c;
        valid_d = 1'b1;
        acc_d   = '0;
        j_d     = '0;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (d_q != D_W'(EMBED_DIM - 1)) begin
            d_d     = d_q + D_W'(1);
            state_d = LOAD;
          end else begin
            d_d = '0;
            if (i_q != I_W'(SEQ_LEN - 1)) begin
              i_d     = i_q + I_W'(1);
              state_d = LOAD;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = index_q;

endmodule

// File: tb/tb_attn_v_mul.sv
// Scoreboard bench for attn_v_mul on a 4x4 problem with an arithmetic reference model.
module tb_attn_v_mul;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int ED = 4;
  localparam int FB = 14;
  localparam int NE = SL * ED;
  localparam int IXW = $clog2(NE);
  localparam int AW = DW + $clog2(SL);
  localparam int FW = DW * NE;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [DW*SL*SL-1:0] W_flat;
  logic [DW*SL*ED-1:0] V_flat;
  logic busy, done, out_valid;
  logic [DW-1:0] out_data;
  logic [IXW-1:0] out_index;
  logic [FW-1:0] out_flat;

  attn_v_mul #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .EMBED_DIM(ED), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .start(start), .W_flat(W_flat), .V_flat(V_flat),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_flat(out_flat)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; logic [DW-1:0] val;} exp_t;
  exp_t sb_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int w_m [SL][SL];
  int v_m [SL][ED];
  logic [FW-1:0] exp_flat;

  task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  // Reference: exact products, floor shift, accumulate in an AW-bit signed register.
  function automatic logic [DW-1:0] ref_elem(input int i, input int d);
    logic signed [AW-1:0] acc;
    longint p;
    longint a;
    acc = '0;
    for (int j = 0; j < SL; j++) begin
      p = longint'(w_m[i][j]) * longint'(v_m[j][d]);
      acc = acc + AW'(p >>> FB);
    end
    a = longint'(acc);
`ifdef ATTN_V_SATURATE_EN
    if (a > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (a < -64'sd2147483648) return 32'h8000_0000;
`endif
    return a[DW-1:0];
  endfunction

  task automatic load_and_expect();
    exp_t e;
    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) W_flat[(m*SL+n)*DW +: DW] = DW'(w_m[m][n]);
      for (int n = 0; n < ED; n++) V_flat[(m*ED+n)*DW +: DW] = DW'(v_m[m][n]);
    end
    for (int i = 0; i < SL; i++)
      for (int d = 0; d < ED; d++) begin
        e.idx = i * ED + d;
        e.val = ref_elem(i, d);
        sb_q.push_back(e);
        exp_flat[e.idx*DW +: DW] = e.val;
      end
  endtask

  // Monitor: pops on every handshake and checks that a stalled element stays put.
  logic held = 1'b0;
  logic [DW-1:0] held_data;
  logic [IXW-1:0] held_idx;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", FW'(out_valid), FW'(1));
        check("hold_data", FW'(out_data), FW'(held_data));
        check("hold_index", FW'(out_index), FW'(held_idx));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got index %0d data %0h, expected no element", out_index, out_data);
        end else begin
          e = sb_q.pop_front();
          check("out_index", FW'(out_index), FW'(e.idx));
          check("out_data", FW'(out_data), FW'(e.val));
        end
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      held_idx = out_index;
    end
  end

  // mode 0: ready high, 1: 5-cycle stall at index 3, 2: random ready, 3: extra start while busy.
  task automatic run(input string nm, input int mode, input int exp_cycles);
    int cyc;
    int hold;
    int extra;
    bit dropped;
    load_and_expect();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, "_busy_start"}, FW'(busy), FW'(1));
    cyc = 0; hold = 0; dropped = 1'b0;
    while (!done && cyc < 3000) begin
      start = (mode == 3 && cyc == 30);
      case (mode)
        1: begin
          if (hold > 0) begin
            hold--;
            out_ready = 1'b0;
          end else if (!dropped && out_valid && out_index == IXW'(3)) begin
            dropped = 1'b1;
            hold = 4;
            out_ready = 1'b0;
          end else out_ready = 1'b1;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({nm, "_done"}, FW'(done), FW'(1));
    check({nm, "_busy_at_done"}, FW'(busy), FW'(0));
    if (exp_cycles >= 0) check({nm, "_latency"}, FW'(cyc), FW'(exp_cycles));
    check({nm, "_out_flat"}, out_flat, exp_flat);
    check({nm, "_sb_drained"}, FW'(sb_q.size()), FW'(0));
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check({nm, "_quiet_after_done"}, FW'(extra), FW'(0));
  endtask

  task automatic set_identity();
    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) w_m[m][n] = (m == n) ? 16384 : 0;
      for (int n = 0; n < ED; n++) v_m[m][n] = 100 * m + n;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    W_flat = '0; V_flat = '0; exp_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", FW'(busy), FW'(0));
    check("rst_done", FW'(done), FW'(0));
    check("rst_valid", FW'(out_valid), FW'(0));
    check("rst_data", FW'(out_data), FW'(0));
    check("rst_index", FW'(out_index), FW'(0));
    check("rst_flat", out_flat, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_identity();
    run("identity", 0, 160);

    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) w_m[m][n] = 4096;
      for (int n = 0; n < ED; n++) v_m[m][n] = 16384 * (n + 1);
    end
    run("average", 0, 160);

    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) w_m[m][n] = (m == n) ? 8192 : 0;
      for (int n = 0; n < ED; n++) v_m[m][n] = -3;
    end
    run("floor", 0, 160);

    set_identity();
    run("backpressure", 1, 165);

    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) w_m[m][n] = 32'h0040_0000;
      for (int n = 0; n < ED; n++) v_m[m][n] = 32'h0040_0000;
    end
    run("overflow", 0, 160);

    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) w_m[m][n] = 32'h4000_0000;
      for (int n = 0; n < ED; n++) v_m[m][n] = 32'h4000_0000;
    end
    run("big_operands", 0, 160);

    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) w_m[m][n] = int'($urandom_range(0, 65536)) - 32768;
      for (int n = 0; n < ED; n++) v_m[m][n] = int'($urandom_range(0, 2000000)) - 1000000;
    end
    run("rand_moderate", 2, -1);

    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) w_m[m][n] = int'($urandom);
      for (int n = 0; n < ED; n++) v_m[m][n] = int'($urandom);
    end
    run("rand_full", 2, -1);

    set_identity();
    run("start_while_busy", 3, 160);

    // Abort mid-run: outputs clear on the next edge and no done follows.
    for (int m = 0; m < SL; m++)
      for (int n = 0; n < ED; n++) v_m[m][n] = 7 * m - 5 * n + 1;
    load_and_expect();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", FW'(busy), FW'(0));
    check("abort_done", FW'(done), FW'(0));
    check("abort_valid", FW'(out_valid), FW'(0));
    check("abort_data", FW'(out_data), FW'(0));
    check("abort_index", FW'(out_index), FW'(0));
    check("abort_flat", out_flat, '0);
    rst = 1'b0;
    sb_q.delete();
    begin
      int dn;
      dn = 0;
      repeat (200) begin
        @(posedge clk); #1;
        if (done || busy || out_valid) dn++;
      end
      check("abort_no_done", FW'(dn), FW'(0));
    end

    set_identity();
    run("after_abort", 0, 160);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
